// File: rtl/fetch_buffer.sv
// fetch_buffer: dual-write, dual-read circular instruction buffer between fetch and a dual decoder
// Ports: clk/reset (sync, active-high), flush (redirect), wr_valid_a/b + wr_instr_a/b + wr_pc_a/b (fetch pair),
//        in_ready (room for two), out_valid_a/b + out_instr_a/b + out_pc_a/b (head pair), issue_cnt (pops), occupancy.
module fetch_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_valid_a,
  input  logic                     wr_valid_b,
  input  logic [31:0]              wr_instr_a,
  input  logic [31:0]              wr_instr_b,
  input  logic [31:0]              wr_pc_a,
  input  logic [31:0]              wr_pc_b,
  output logic                     in_ready,
  output logic                     out_valid_a,
  output logic                     out_valid_b,
  output logic [31:0]              out_instr_a,
  output logic [31:0]              out_instr_b,
  output logic [31:0]              out_pc_a,
  output logic [31:0]              out_pc_b,
  input  logic [1:0]               issue_cnt,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [OW-1:0] r_occ;
  logic          w_push_a, w_push_b;
  logic [OW-1:0] w_pushes, w_req, w_pops;
  logic [AW-1:0] w_head_b, w_tail_b;
  // Readiness always reserves room for a full pair, so a single push never needs a partial accept.
  assign in_ready    = r_occ <= OW'(DEPTH - 2);
  assign w_push_a    = in_ready && wr_valid_a;
  assign w_push_b    = w_push_a && wr_valid_b;
  assign w_pushes    = OW'(w_push_a) + OW'(w_push_b);
  assign w_req       = (issue_cnt == 2'd3) ? '0 : OW'(issue_cnt);
  assign w_pops      = (w_req > r_occ) ? r_occ : w_req;
  assign w_head_b    = r_head + AW'(1);
  assign w_tail_b    = r_tail + AW'(1);
  assign occupancy   = r_occ;
  assign out_valid_a = r_occ >= OW'(1);
  assign out_valid_b = r_occ >= OW'(2);
  assign out_instr_a = out_valid_a ? r_instr[r_head]   : '0;
  assign out_pc_a    = out_valid_a ? r_pc[r_head]      : '0;
  assign out_instr_b = out_valid_b ? r_instr[w_head_b] : '0;
  assign out_pc_b    = out_valid_b ? r_pc[w_head_b]    : '0;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_head <= r_head + AW'(w_pops);
      r_tail <= r_tail + AW'(w_pushes);
      r_occ  <= r_occ + w_pushes - w_pops;
    end
  end
  // Storage is not reset; writes under flush/reset land in slots that the cleared pointers treat as empty.
  always_ff @(posedge clk) begin
    if (w_push_a) begin
      r_instr[r_tail] <= wr_instr_a;
      r_pc[r_tail]    <= wr_pc_a;
    end
    if (w_push_b) begin
      r_instr[w_tail_b] <= wr_instr_b;
      r_pc[w_tail_b]    <= wr_pc_b;
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed self-checking bench for fetch_buffer
module tb_fetch_buffer;
  localparam int DEPTH = 8;
  logic        clk = 1'b0;
  logic        reset = 1'b1, flush = 1'b0, wr_valid_a = 1'b0, wr_valid_b = 1'b0;
  logic [31:0] wr_instr_a = '0, wr_instr_b = '0, wr_pc_a = '0, wr_pc_b = '0;
  logic [1:0]  issue_cnt = '0;
  logic        in_ready, out_valid_a, out_valid_b;
  logic [31:0] out_instr_a, out_instr_b, out_pc_a, out_pc_b;
  logic [3:0]  occupancy;
  int checks = 0;
  int failures = 0;
  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_valid_a(wr_valid_a), .wr_valid_b(wr_valid_b),
    .wr_instr_a(wr_instr_a), .wr_instr_b(wr_instr_b),
    .wr_pc_a(wr_pc_a), .wr_pc_b(wr_pc_b),
    .in_ready(in_ready), .out_valid_a(out_valid_a), .out_valid_b(out_valid_b),
    .out_instr_a(out_instr_a), .out_instr_b(out_instr_b),
    .out_pc_a(out_pc_a), .out_pc_b(out_pc_b),
    .issue_cnt(issue_cnt), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] iw(input logic [31:0] pc);
    return pc ^ 32'h13A0_0000;
  endfunction
  task automatic cyc(input logic fl, input logic va, input logic vb, input logic [31:0] ia, input logic [31:0] pa,
                     input logic [31:0] ib, input logic [31:0] pb, input logic [1:0] ic);
    flush = fl; wr_valid_a = va; wr_valid_b = vb;
    wr_instr_a = ia; wr_pc_a = pa; wr_instr_b = ib; wr_pc_b = pb; issue_cnt = ic;
    @(posedge clk); #1;
    flush = 1'b0; wr_valid_a = 1'b0; wr_valid_b = 1'b0; issue_cnt = 2'd0;
  endtask
  task automatic push2(input logic [31:0] pa, input logic [1:0] ic);
    cyc(1'b0, 1'b1, 1'b1, iw(pa), pa, iw(pa + 32'd4), pa + 32'd4, ic);
  endtask
  task automatic push1(input logic [31:0] pa);
    cyc(1'b0, 1'b1, 1'b0, iw(pa), pa, 32'h0, 32'h0, 2'd0);
  endtask
  task automatic pop(input logic [1:0] ic);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, ic);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  task automatic test_reset();
    push2(32'h40, 2'd0);
    reset = 1'b1; flush = 1'b1; wr_valid_a = 1'b1; wr_valid_b = 1'b1; issue_cnt = 2'd1;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0; wr_valid_a = 1'b0; wr_valid_b = 1'b0; issue_cnt = 2'd0;
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin failures++; $display("FAIL reset_valid got %b%b want 00", out_valid_a, out_valid_b); end
    checks++; if (out_pc_a !== 32'h0 || out_instr_a !== 32'h0 || out_pc_b !== 32'h0 || out_instr_b !== 32'h0) begin failures++; $display("FAIL reset_data got %h %h want 0", out_pc_a, out_instr_a); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask
  task automatic test_dual_push();
    do_reset();
    wr_valid_a = 1'b1; wr_valid_b = 1'b1;
    wr_instr_a = 32'h00A00093; wr_pc_a = 32'h0; wr_instr_b = 32'h00108113; wr_pc_b = 32'h4;
    #1;
    checks++; if (out_valid_a !== 1'b0 || occupancy !== 4'd0) begin failures++; $display("FAIL no_fallthrough got v=%b occ=%0d want v=0 occ=0", out_valid_a, occupancy); end
    @(posedge clk); #1;
    wr_valid_a = 1'b0; wr_valid_b = 1'b0;
    checks++; if (out_valid_a !== 1'b1 || out_valid_b !== 1'b1) begin failures++; $display("FAIL dual_valid got %b%b want 11", out_valid_a, out_valid_b); end
    checks++; if (out_pc_a !== 32'h0 || out_pc_b !== 32'h4) begin failures++; $display("FAIL dual_pc got %h %h want 0 4", out_pc_a, out_pc_b); end
    checks++; if (out_instr_a !== 32'h00A00093 || out_instr_b !== 32'h00108113) begin failures++; $display("FAIL dual_instr got %h %h want 00a00093 00108113", out_instr_a, out_instr_b); end
    checks++; if (occupancy !== 4'd2) begin failures++; $display("FAIL dual_occ got %0d want 2", occupancy); end
    push1(32'h8);
    checks++; if (occupancy !== 4'd3 || out_pc_a !== 32'h0) begin failures++; $display("FAIL single_push got occ=%0d pc=%h want 3 0", occupancy, out_pc_a); end
    cyc(1'b0, 1'b0, 1'b1, 32'h1, 32'hC, 32'h1, 32'hC, 2'd0);
    checks++; if (occupancy !== 4'd3) begin failures++; $display("FAIL b_without_a got %0d want 3", occupancy); end
  endtask
  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 3; k++) push2(32'h100 + 32'(8 * k), 2'd0);
    checks++; if (occupancy !== 4'd6 || in_ready !== 1'b1) begin failures++; $display("FAIL fill6 got occ=%0d rdy=%b want 6 1", occupancy, in_ready); end
    push2(32'h118, 2'd0);
    checks++; if (occupancy !== 4'd8 || in_ready !== 1'b0) begin failures++; $display("FAIL fill8 got occ=%0d rdy=%b want 8 0", occupancy, in_ready); end
    push2(32'h900, 2'd0);
    checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL overflow_occ got %0d want 8", occupancy); end
    checks++; if (out_pc_a !== 32'h100 || out_pc_b !== 32'h104 || out_instr_a !== iw(32'h100)) begin failures++; $display("FAIL overflow_data got %h %h want 100 104", out_pc_a, out_pc_b); end
    pop(2'd1);
    checks++; if (occupancy !== 4'd7 || in_ready !== 1'b0 || out_pc_a !== 32'h104) begin failures++; $display("FAIL occ7 got occ=%0d rdy=%b pc=%h want 7 0 104", occupancy, in_ready, out_pc_a); end
    for (int j = 0; j < 3; j++) begin
      pop(2'd2);
      checks++; if (out_pc_a !== 32'h10C + 32'(8 * j)) begin failures++; $display("FAIL drain_pc%0d got %h want %h", j, out_pc_a, 32'h10C + 32'(8 * j)); end
    end
    checks++; if (occupancy !== 4'd1 || out_valid_b !== 1'b0 || out_pc_b !== 32'h0) begin failures++; $display("FAIL drain_one got occ=%0d vb=%b pcb=%h want 1 0 0", occupancy, out_valid_b, out_pc_b); end
    pop(2'd2);
    checks++; if (occupancy !== 4'd0 || out_valid_a !== 1'b0) begin failures++; $display("FAIL drain_empty got occ=%0d va=%b want 0 0", occupancy, out_valid_a); end
  endtask
  task automatic test_partial_issue();
    do_reset();
    push2(32'h200, 2'd0);
    push1(32'h208);
    pop(2'd3);
    checks++; if (occupancy !== 4'd3 || out_pc_a !== 32'h200) begin failures++; $display("FAIL issue3 got occ=%0d pc=%h want 3 200", occupancy, out_pc_a); end
    pop(2'd1);
    checks++; if (occupancy !== 4'd2 || out_pc_a !== 32'h204 || out_pc_b !== 32'h208) begin failures++; $display("FAIL partial got occ=%0d %h %h want 2 204 208", occupancy, out_pc_a, out_pc_b); end
    pop(2'd1);
    checks++; if (occupancy !== 4'd1 || out_pc_a !== 32'h208 || out_valid_b !== 1'b0) begin failures++; $display("FAIL partial2 got occ=%0d %h vb=%b want 1 208 0", occupancy, out_pc_a, out_valid_b); end
    pop(2'd2);
    checks++; if (occupancy !== 4'd0 || out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || out_pc_a !== 32'h0) begin failures++; $display("FAIL clip_pop got occ=%0d va=%b want 0 0", occupancy, out_valid_a); end
    pop(2'd2);
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL underflow got %0d want 0", occupancy); end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 3; k++) push2(32'h300 + 32'(8 * k), 2'd0);
    for (int k = 0; k < 3; k++) pop(2'd2);
    push1(32'h318);
    push2(32'h31C, 2'd0);
    checks++; if (occupancy !== 4'd3 || out_pc_a !== 32'h318 || out_pc_b !== 32'h31C) begin failures++; $display("FAIL wrap_pre got occ=%0d %h %h want 3 318 31c", occupancy, out_pc_a, out_pc_b); end
    pop(2'd1);
    checks++; if (out_pc_a !== 32'h31C || out_pc_b !== 32'h320 || out_instr_b !== iw(32'h320)) begin failures++; $display("FAIL wrap_read got %h %h want 31c 320", out_pc_a, out_pc_b); end
    checks++; if (occupancy !== 4'd2) begin failures++; $display("FAIL wrap_occ got %0d want 2", occupancy); end
  endtask
  task automatic test_flush();
    do_reset();
    push2(32'h400, 2'd0);
    push2(32'h408, 2'd0);
    push1(32'h410);
    checks++; if (occupancy !== 4'd5) begin failures++; $display("FAIL preflush got %0d want 5", occupancy); end
    cyc(1'b1, 1'b1, 1'b1, iw(32'h500), 32'h500, iw(32'h504), 32'h504, 2'd2);
    checks++; if (occupancy !== 4'd0 || out_valid_a !== 1'b0 || in_ready !== 1'b1 || out_pc_a !== 32'h0) begin failures++; $display("FAIL flush got occ=%0d va=%b rdy=%b want 0 0 1", occupancy, out_valid_a, in_ready); end
    push2(32'h4A0, 2'd0);
    checks++; if (occupancy !== 4'd2 || out_pc_a !== 32'h4A0 || out_pc_b !== 32'h4A4) begin failures++; $display("FAIL postflush got occ=%0d %h %h want 2 4a0 4a4", occupancy, out_pc_a, out_pc_b); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] q[$];
    do_reset();
    for (int k = 0; k < 2; k++) begin
      push2(32'h600 + 32'(8 * k), 2'd0);
      q.push_back(32'h600 + 32'(8 * k));
      q.push_back(32'h604 + 32'(8 * k));
    end
    for (int k = 0; k < 3; k++) begin
      push2(32'h610 + 32'(8 * k), 2'd2);
      void'(q.pop_front());
      void'(q.pop_front());
      q.push_back(32'h610 + 32'(8 * k));
      q.push_back(32'h614 + 32'(8 * k));
      checks++; if (occupancy !== 4'(q.size())) begin failures++; $display("FAIL b2b_occ%0d got %0d want %0d", k, occupancy, q.size()); end
      checks++; if (out_pc_a !== q[0] || out_pc_b !== q[1] || out_instr_a !== iw(q[0])) begin failures++; $display("FAIL b2b_order%0d got %h %h want %h %h", k, out_pc_a, out_pc_b, q[0], q[1]); end
    end
    for (int k = 0; k < 2; k++) begin
      pop(2'd2);
      void'(q.pop_front());
      void'(q.pop_front());
      checks++; if (occupancy !== 4'(q.size())) begin failures++; $display("FAIL b2b_drain%0d got %0d want %0d", k, occupancy, q.size()); end
    end
  endtask
  initial begin
    @(posedge clk); #1;
    reset = 1'b0;
    test_reset();
    test_dual_push();
    test_fill();
    test_partial_issue();
    test_wrap();
    test_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
